// File: rtl/station_dispatch_if.sv
// Decoder-to-dispatch and dispatch-to-station signal bundle.
// The decoder side (master) drives the dec_* offer and the station idle mask; the dispatcher (slave) drives the rest.
interface station_dispatch_if;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_iop;
    logic [2:0]  dec_init;
    logic [15:0] dec_pc;
    logic [15:0] dec_k16;
    logic [3:0]  st_complete;
    logic [3:0]  st_feed;
    logic [31:0] st_iop;
    logic [2:0]  st_init;
    logic [15:0] st_pc;
    logic [15:0] st_k16;
    logic [2:0]  q_level;

    modport master (
        output dec_valid, dec_iop, dec_init, dec_pc, dec_k16, st_complete,
        input  dec_ready, st_feed, st_iop, st_init, st_pc, st_k16, q_level
    );

    modport slave (
        input  dec_valid, dec_iop, dec_init, dec_pc, dec_k16, st_complete,
        output dec_ready, st_feed, st_iop, st_init, st_pc, st_k16, q_level
    );
endinterface

// File: rtl/station_dispatch.sv
// In-order uop dispatch queue feeding four reservation stations with round-robin
// station selection; head payload is broadcast and st_feed strobes the chosen station.
module station_dispatch #(
    parameter int N_ST  = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               a_rst,
    input  logic               flush,
    station_dispatch_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [66:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    rr;
    logic [1:0]    sel_idx;
    logic          sel_found;
    logic          push;
    logic          pop;
    logic [66:0]   head;

    // Handshake: a uop transfers at a rising edge where dec_valid and dec_ready are both
    // high; dec_ready looks only at the registered count, so a pop never frees a slot early.
    assign bus.dec_ready = a_rst & ~flush & (count != CW'(DEPTH));
    assign push          = bus.dec_valid & bus.dec_ready;

    assign head = mem[rd_ptr];
    assign {bus.st_iop, bus.st_init, bus.st_pc, bus.st_k16} = head;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr;
        for (int k = 0; k < N_ST; k++) begin
            if (!sel_found && bus.st_complete[rr + 2'(k)]) begin
                sel_found = 1'b1;
                sel_idx   = rr + 2'(k);
            end
        end
    end

    assign pop         = a_rst & ~flush & (count != '0) & sel_found;
    assign bus.st_feed = pop ? (4'b0001 << sel_idx) : 4'b0000;
    assign bus.q_level = count;

    // Payload storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.dec_iop, bus.dec_init, bus.dec_pc, bus.dec_k16};
        end
    end

    always_ff @(posedge clk) begin
        if (!a_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rr     <= sel_idx + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_station_dispatch.sv
// Self-checking bench for station_dispatch: a per-cycle reference monitor with an
// expected-payload queue plus directed scenario tasks.
module tb_station_dispatch;
    logic clk;
    logic a_rst;
    logic flush;

    station_dispatch_if bus ();

    station_dispatch #(.N_ST(4), .DEPTH(4)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .flush (flush),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 1'b0;

    logic [66:0] exp_q [$];
    logic [1:0]  m_rr = 2'd0;
    logic [1:0]  m_idx;
    logic [3:0]  m_feed;
    logic        m_ready;
    logic        m_found;
    logic [66:0] m_head;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        a_rst           = 1'b0;
        flush           = 1'b0;
        bus.dec_valid   = 1'b0;
        bus.dec_iop     = '0;
        bus.dec_init    = '0;
        bus.dec_pc      = '0;
        bus.dec_k16     = '0;
        bus.st_complete = 4'b0000;
    end

    // ---------------- reference monitor ----------------
    // Inputs change just after posedge, so the negedge sees settled outputs.
    always @(negedge clk) begin
        m_ready = a_rst && !flush && (exp_q.size() != 4);
        m_found = 1'b0;
        m_idx   = m_rr;
        m_feed  = 4'b0000;
        if (a_rst && !flush && exp_q.size() != 0) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_found && bus.st_complete[m_rr + 2'(k)]) begin
                    m_found = 1'b1;
                    m_idx   = m_rr + 2'(k);
                end
            end
            if (m_found) m_feed = 4'b0001 << m_idx;
        end
        if (mon_en) begin
            tests_run++;
            if (bus.dec_ready !== m_ready) begin
                tests_failed++;
                $display("FAIL mon_dec_ready t=%0t got=%b exp=%b", $time, bus.dec_ready, m_ready);
            end
            tests_run++;
            if (bus.st_feed !== m_feed) begin
                tests_failed++;
                $display("FAIL mon_st_feed t=%0t got=%b exp=%b", $time, bus.st_feed, m_feed);
            end
            tests_run++;
            if (bus.q_level !== 3'(exp_q.size())) begin
                tests_failed++;
                $display("FAIL mon_q_level t=%0t got=%0d exp=%0d", $time, bus.q_level, exp_q.size());
            end
            if (m_feed != 4'b0000) begin
                m_head = exp_q[0];
                tests_run++;
                if ({bus.st_iop, bus.st_init, bus.st_pc, bus.st_k16} !== m_head) begin
                    tests_failed++;
                    $display("FAIL mon_payload t=%0t got=%h exp=%h", $time,
                             {bus.st_iop, bus.st_init, bus.st_pc, bus.st_k16}, m_head);
                end
            end
        end
        if (!a_rst || flush) begin
            exp_q.delete();
            m_rr = 2'd0;
        end else begin
            if (m_feed != 4'b0000) begin
                void'(exp_q.pop_front());
                m_rr = m_idx + 2'd1;
            end
            if (bus.dec_valid && m_ready) begin
                exp_q.push_back({bus.dec_iop, bus.dec_init, bus.dec_pc, bus.dec_k16});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] iop, input logic [15:0] pc);
        bus.dec_valid = 1'b1;
        bus.dec_iop   = iop;
        bus.dec_init  = 3'(iop[2:0]);
        bus.dec_pc    = pc;
        bus.dec_k16   = 16'(iop[15:0] ^ 16'hA5A5);
    endtask

    task automatic random_offer();
        offer($urandom_range(32'h7FFF_FFFF, 0), 16'($urandom_range(16'hFFFF, 0)));
    endtask

    task automatic do_reset();
        a_rst         = 1'b0;
        bus.dec_valid = 1'b0;
        step();
        a_rst = 1'b1;
        step();
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        bus.dec_valid   = 1'b0;
        bus.st_complete = 4'b1111;
        while (bus.q_level !== 3'd0 && cyc < 20) begin
            step();
            cyc++;
        end
        tests_run++;
        if (bus.q_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL drain_timeout got=%0d exp=0", bus.q_level);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        a_rst = 1'b0;
        step();
        step();
        @(negedge clk);
        tests_run++;
        if (bus.q_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_q_level got=%0d exp=0", bus.q_level);
        end
        tests_run++;
        if (bus.st_feed !== 4'b0000 || bus.dec_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got feed=%b ready=%b exp feed=0000 ready=0", bus.st_feed, bus.dec_ready);
        end
        a_rst = 1'b1;
        step();
        mon_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.dec_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.dec_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.st_complete = 4'b1111;
        offer(32'h0040_1234, 16'h8000);
        step();
        bus.dec_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.st_feed !== 4'b0001 || bus.st_iop !== 32'h0040_1234 || bus.st_pc !== 16'h8000) begin
            tests_failed++;
            $display("FAIL single_dispatch got feed=%b iop=%h pc=%h exp feed=0001 iop=00401234 pc=8000",
                     bus.st_feed, bus.st_iop, bus.st_pc);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (bus.q_level !== 3'd0 || bus.st_feed !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_after got q=%0d feed=%b exp q=0 feed=0000", bus.q_level, bus.st_feed);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  seq [5];
        logic [31:0] iops [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) iops[i] = 32'h1000_0000 + 32'(i * 17);
        do_reset();
        bus.st_complete = 4'b1111;
        offer(iops[0], 16'h0100);
        step();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) offer(iops[i+1], 16'(16'h0100 + i + 1));
            else bus.dec_valid = 1'b0;
            @(negedge clk);
            tests_run++;
            if (bus.st_feed !== seq[i] || bus.st_iop !== iops[i]) begin
                tests_failed++;
                $display("FAIL rr_seq_%0d got feed=%b iop=%h exp feed=%b iop=%h",
                         i, bus.st_feed, bus.st_iop, seq[i], iops[i]);
            end
            step();
        end
    endtask

    task automatic test_skip_busy();
        do_reset();
        bus.st_complete = 4'b1010;
        offer(32'hAAAA_0001, 16'h0200);
        step();
        offer(32'hAAAA_0002, 16'h0201);
        @(negedge clk);
        tests_run++;
        if (bus.st_feed !== 4'b0010) begin
            tests_failed++;
            $display("FAIL skip_first got=%b exp=0010", bus.st_feed);
        end
        step();
        bus.dec_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.st_feed !== 4'b1000) begin
            tests_failed++;
            $display("FAIL skip_second got=%b exp=1000", bus.st_feed);
        end
        step();
    endtask

    task automatic test_full();
        do_reset();
        bus.st_complete = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            random_offer();
            step();
        end
        offer(32'h5555_0005, 16'h0505);
        @(negedge clk);
        tests_run++;
        if (bus.q_level !== 3'd4 || bus.dec_ready !== 1'b0 || bus.st_feed !== 4'b0000) begin
            tests_failed++;
            $display("FAIL full_state got q=%0d ready=%b feed=%b exp q=4 ready=0 feed=0000",
                     bus.q_level, bus.dec_ready, bus.st_feed);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (bus.q_level !== 3'd4) begin
            tests_failed++;
            $display("FAIL full_fifth_rejected got=%0d exp=4", bus.q_level);
        end
        step();
        bus.st_complete = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (bus.st_feed !== 4'b0100 || bus.dec_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_release got feed=%b ready=%b exp feed=0100 ready=0", bus.st_feed, bus.dec_ready);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (bus.dec_ready !== 1'b1 || bus.q_level !== 3'd3) begin
            tests_failed++;
            $display("FAIL full_ready_back got ready=%b q=%0d exp ready=1 q=3", bus.dec_ready, bus.q_level);
        end
        step();
        drain();
    endtask

    task automatic test_flush_or_reset(input bit use_reset);
        do_reset();
        bus.st_complete = 4'b1111;
        random_offer();
        step();
        bus.dec_valid   = 1'b0;
        step();
        bus.st_complete = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            random_offer();
            step();
        end
        bus.dec_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.q_level !== 3'd3) begin
            tests_failed++;
            $display("FAIL clear_pre_level mode=%0d got=%0d exp=3", use_reset, bus.q_level);
        end
        step();
        bus.st_complete = 4'b1111;
        offer(32'hDEAD_BEEF, 16'hDEAD);
        if (use_reset) a_rst = 1'b0;
        else flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.st_feed !== 4'b0000 || bus.dec_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_cycle mode=%0d got feed=%b ready=%b exp feed=0000 ready=0",
                     use_reset, bus.st_feed, bus.dec_ready);
        end
        step();
        a_rst         = 1'b1;
        flush         = 1'b0;
        bus.dec_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (bus.q_level !== 3'd0 || bus.st_feed !== 4'b0000) begin
                tests_failed++;
                $display("FAIL clear_after_%0d mode=%0d got q=%0d feed=%b exp q=0 feed=0000",
                         c, use_reset, bus.q_level, bus.st_feed);
            end
            step();
        end
        offer(32'h0000_0F0F, 16'h0F0F);
        step();
        bus.dec_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.st_feed !== 4'b0001) begin
            tests_failed++;
            $display("FAIL clear_rr_restart mode=%0d got=%b exp=0001", use_reset, bus.st_feed);
        end
        step();
    endtask

    task automatic test_random_traffic();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(1, 0) == 1) random_offer();
            else bus.dec_valid = 1'b0;
            bus.st_complete = 4'($urandom_range(15, 0));
            step();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip_busy();
        test_full();
        test_flush_or_reset(1'b0);
        test_flush_or_reset(1'b1);
        test_random_traffic();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
